// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, LSU and CSR,
// plus a per-register busy scoreboard for RAW/WAW stalls. Optional macro: RF_WB_BYPASS_EN.
module rf_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                req_valid,
    input  logic [3*ADDR_WIDTH-1:0]   req_rd,
    input  logic [3*DATA_WIDTH-1:0]   req_data,
    output logic [2:0]                req_ready,
    input  logic                      issue_valid,
    input  logic [ADDR_WIDTH-1:0]     issue_rd,
    input  logic [ADDR_WIDTH-1:0]     rs1,
    input  logic [ADDR_WIDTH-1:0]     rs2,
    input  logic [ADDR_WIDTH-1:0]     chk_rd,
    output logic                      stall,
    output logic                      byp1_hit,
    output logic                      byp2_hit,
    output logic [DATA_WIDTH-1:0]     byp_data,
    output logic                      rf_wen,
    output logic [ADDR_WIDTH-1:0]     rf_rd,
    output logic [DATA_WIDTH-1:0]     rf_dataD
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [1:0]            last;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic                  gnt_any;
    logic [1:0]            gnt_idx;
    logic [ADDR_WIDTH-1:0] gnt_rd;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  raw1;
    logic                  raw2;
    logic                  waw;

    // Search starts at the source after the last winner, wrapping mod 3.
    always_comb begin
        gnt_any = |req_valid;
        gnt_idx = 2'd0;
        case (last)
            2'd0:    gnt_idx = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd1:    gnt_idx = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: gnt_idx = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
        endcase
        req_ready = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    end

    always_comb begin
        gnt_rd   = req_rd[2*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
        case (gnt_idx)
            2'd0: begin
                gnt_rd   = req_rd[0 +: ADDR_WIDTH];
                gnt_data = req_data[0 +: DATA_WIDTH];
            end
            2'd1: begin
                gnt_rd   = req_rd[ADDR_WIDTH +: ADDR_WIDTH];
                gnt_data = req_data[DATA_WIDTH +: DATA_WIDTH];
            end
            default: ;
        endcase
    end

    // Clear on commit first so a same-edge issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (rf_wen)
            busy_next[rf_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= 2'd2;
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_dataD <= '0;
            busy     <= '0;
        end else begin
            busy <= busy_next;
            if (gnt_any) begin
                last     <= gnt_idx;
                rf_wen   <= (gnt_rd != '0);
                rf_rd    <= gnt_rd;
                rf_dataD <= gnt_data;
            end else begin
                rf_wen <= 1'b0;
            end
        end
    end

    assign raw1 = busy[rs1] && (rs1 != '0);
    assign raw2 = busy[rs2] && (rs2 != '0);
    assign waw  = busy[chk_rd] && (chk_rd != '0);

`ifdef RF_WB_BYPASS_EN
    // The committing write is forwarded, lifting the RAW stall a cycle early.
    assign byp1_hit = rf_wen && (rf_rd == rs1) && (rs1 != '0);
    assign byp2_hit = rf_wen && (rf_rd == rs2) && (rs2 != '0);
    assign byp_data = rf_dataD;
`else
    assign byp1_hit = 1'b0;
    assign byp2_hit = 1'b0;
    assign byp_data = '0;
`endif

    assign stall = (raw1 && !byp1_hit) || (raw2 && !byp2_hit) || waw;

endmodule
